// File: rtl/vga_fb_arbiter_if.sv
// Writer-side port of the framebuffer arbiter: held request, one-cycle ack,
// and a sticky out-of-range error flag.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              wr_vblank_only;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;

    modport master (
        output wr_vblank_only, wr_req, wr_addr, wr_data,
        input  wr_ack, wr_err
    );

    modport slave (
        input  wr_vblank_only, wr_req, wr_addr, wr_data,
        output wr_ack, wr_err
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display fetches (one per 4-pixel cell)
// always win over writer requests; every output is registered.
module vga_fb_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    vga_fb_arbiter_if.slave   wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel_data,
    output logic              frame_start
);
    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WRITE} state_t;

    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);

    state_t            state_reg, state_next;
    logic [19:0]       last_coord_reg, last_coord_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_we_reg, mem_we_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] pixel_data_reg, pixel_data_next;
    logic              wr_ack_reg, wr_ack_next;
    logic              wr_err_reg, wr_err_next;
    logic              frame_start_reg, frame_start_next;

    logic [ADDR_W-1:0] cell_x, cell_y, fetch_addr;
    logic              fetch_pending, wr_grantable;

    assign cell_x = ADDR_W'(pixel_x[9:2]);
    assign cell_y = ADDR_W'(pixel_y[9:2]);
    // Row stride of 160 built from shifts: y*128 + y*32 + x.
    assign fetch_addr = (cell_y << 7) + (cell_y << 5) + cell_x;

    assign fetch_pending = video_on && (pixel_x[1:0] == 2'b00)
                           && ({pixel_y, pixel_x} != last_coord_reg);
    assign wr_grantable  = wr.wr_req && (!wr.wr_vblank_only || !video_on);

    always_comb begin
        state_next       = state_reg;
        last_coord_next  = last_coord_reg;
        mem_addr_next    = mem_addr_reg;
        mem_we_next      = 1'b0;
        mem_wdata_next   = mem_wdata_reg;
        pixel_data_next  = pixel_data_reg;
        wr_ack_next      = 1'b0;
        wr_err_next      = wr_err_reg;
        frame_start_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fetch_pending) begin
                    state_next       = FETCH;
                    last_coord_next  = {pixel_y, pixel_x};
                    mem_addr_next    = fetch_addr;
                    frame_start_next = (pixel_x == '0) && (pixel_y == '0);
                end else if (wr_grantable) begin
                    state_next     = WRITE;
                    mem_addr_next  = wr.wr_addr;
                    mem_wdata_next = wr.wr_data;
                    wr_ack_next    = 1'b1;
                    // Out-of-range writes are acknowledged but never reach the RAM.
                    if (wr.wr_addr < FB_SIZE) begin
                        mem_we_next = 1'b1;
                    end else begin
                        wr_err_next = 1'b1;
                    end
                end
            end
            FETCH:   state_next = CAPTURE;
            CAPTURE: begin
                state_next      = IDLE;
                pixel_data_next = mem_rdata;
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_reg != CAPTURE && !video_on) begin
            pixel_data_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            last_coord_reg  <= {10'h3FF, 10'h3FF};
            mem_addr_reg    <= '0;
            mem_we_reg      <= 1'b0;
            mem_wdata_reg   <= '0;
            pixel_data_reg  <= '0;
            wr_ack_reg      <= 1'b0;
            wr_err_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_coord_reg  <= last_coord_next;
            mem_addr_reg    <= mem_addr_next;
            mem_we_reg      <= mem_we_next;
            mem_wdata_reg   <= mem_wdata_next;
            pixel_data_reg  <= pixel_data_next;
            wr_ack_reg      <= wr_ack_next;
            wr_err_reg      <= wr_err_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign mem_addr    = mem_addr_reg;
    assign mem_we      = mem_we_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign pixel_data  = pixel_data_reg;
    assign frame_start = frame_start_reg;
    assign wr.wr_ack   = wr_ack_reg;
    assign wr.wr_err   = wr_err_reg;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios then randomized traffic, all
// checked cycle by cycle against a timeline-based reference model.
module tb_vga_fb_arbiter;
    localparam int FB_W   = 160;
    localparam int FB_H   = 120;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              video_on = 1'b0;
    logic [9:0]        pixel_x = '0;
    logic [9:0]        pixel_y = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] pixel_data;
    logic              frame_start;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wif ();

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .wr         (wif.slave),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pixel_data (pixel_data),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Stimulus applied at the start of each cycle
    logic              s_rst = 1'b1, s_von = 1'b0, s_vbo = 1'b0, s_req = 1'b0;
    logic [9:0]        s_x = '0, s_y = '0;
    logic [ADDR_W-1:0] s_waddr = '0;
    logic [DATA_W-1:0] s_wdata = '0;
    int                wr_mode = 0;   // 0 directed, 1 sporadic random, 2 back-to-back
    logic              ack_seen = 1'b0;

    // Bench-side RAM and its read pipeline
    logic [7:0]        ram [0:32767];
    logic [ADDR_W-1:0] ram_addr_q = '0;

    // Reference model
    logic [7:0]        model_ram [0:32767];
    int                cyc = 0, free_at = 0, cap_at = -1, last_x = 1023, last_y = 1023;
    logic [ADDR_W-1:0] cap_addr = '0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_pix = '0;
    logic              e_we = 1'b0, e_ack = 1'b0, e_err = 1'b0, e_frame = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        free_at = 0; cap_at = -1; last_x = 1023; last_y = 1023;
        e_addr = '0; e_wdata = '0; e_pix = '0;
        e_we = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_frame = 1'b0;
    endtask

    // Expected outputs for the next cycle from this cycle's inputs.
    task automatic model_step();
        int xi, yi;
        xi = int'(s_x);
        yi = int'(s_y);
        e_we = 1'b0; e_ack = 1'b0; e_frame = 1'b0;
        if (cap_at == cyc) e_pix = model_ram[cap_addr];
        else if (!s_von)   e_pix = '0;
        if (cyc >= free_at) begin
            if (s_von && (xi % 4 == 0) && (xi != last_x || yi != last_y)) begin
                e_addr  = ADDR_W'(((yi / 4) * FB_W + xi / 4) % 32768);
                cap_addr = e_addr;
                cap_at  = cyc + 2;
                free_at = cyc + 3;
                last_x  = xi;
                last_y  = yi;
                e_frame = (xi == 0 && yi == 0);
            end else if (s_req && (!s_vbo || !s_von)) begin
                free_at = cyc + 2;
                e_ack   = 1'b1;
                e_addr  = s_waddr;
                e_wdata = s_wdata;
                if (int'(s_waddr) < FB_W * FB_H) begin
                    e_we = 1'b1;
                    model_ram[s_waddr] = s_wdata;
                end else begin
                    e_err = 1'b1;
                end
                $display("write addr=%0d data=%02h %s", s_waddr, s_wdata,
                         (int'(s_waddr) < FB_W * FB_H) ? "stored" : "rejected");
            end
        end
    endtask

    task automatic new_request();
        int r;
        r = $urandom_range(0, 39);
        s_req = 1'b1;
        if (r == 0)      s_waddr = ADDR_W'($urandom_range(FB_W * FB_H, 32767));
        else if (r == 1) s_waddr = ADDR_W'(FB_W * FB_H - 1);
        else             s_waddr = ADDR_W'($urandom_range(0, FB_W * FB_H - 1));
        s_wdata = DATA_W'($urandom);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (ack_seen) begin
            if (wr_mode == 2 || (wr_mode == 1 && $urandom_range(0, 1) == 1)) new_request();
            else s_req = 1'b0;
        end else if (!s_req && wr_mode != 0 && $urandom_range(0, 3) == 0) begin
            new_request();
        end
        mem_rdata = ram[ram_addr_q];
        reset = s_rst; video_on = s_von; pixel_x = s_x; pixel_y = s_y;
        wif.wr_vblank_only = s_vbo; wif.wr_req = s_req;
        wif.wr_addr = s_waddr; wif.wr_data = s_wdata;
        @(negedge clk);
        if (!s_rst) model_reset();
        check_eq("mem_addr",    32'(mem_addr),    32'(e_addr));
        check_eq("mem_we",      32'(mem_we),      32'(e_we));
        check_eq("mem_wdata",   32'(mem_wdata),   32'(e_wdata));
        check_eq("wr_ack",      32'(wif.wr_ack),  32'(e_ack));
        check_eq("wr_err",      32'(wif.wr_err),  32'(e_err));
        check_eq("pixel_data",  32'(pixel_data),  32'(e_pix));
        check_eq("frame_start", 32'(frame_start), 32'(e_frame));
        if (mem_we) ram[mem_addr] = mem_wdata;
        ram_addr_q = mem_addr;
        ack_seen = wif.wr_ack;
        if (s_rst) model_step();
        cyc++;
    endtask

    task automatic wait_writer_idle();
        int n;
        n = 0;
        while (s_req && n < 40) begin
            cycle();
            n++;
        end
        check_eq("writer_idle_timeout", 32'(s_req), 32'd0);
    endtask

    initial begin
        int sx, sy, acks, r;
        logic raster;
        for (int i = 0; i < 32768; i++) begin
            ram[i] = 8'(i * 7 + 3);
            model_ram[i] = 8'(i * 7 + 3);
        end
        ram[162] = 8'hA5;
        model_ram[162] = 8'hA5;

        // Reset with a pending write and active video, then first (0,0)
        s_rst = 1'b0; s_von = 1'b1; s_x = '0; s_y = '0;
        s_req = 1'b1; s_waddr = 15'd500; s_wdata = 8'h11;
        repeat (3) cycle();
        s_rst = 1'b1;
        cycle();
        cycle();
        check_eq("frame_start_after_release", 32'(frame_start), 32'd1);
        check_eq("fetch_addr_origin", 32'(mem_addr), 32'd0);
        s_x = 10'd1;
        repeat (4) cycle();
        wait_writer_idle();

        // Fetch at (8,4) -> address 162, pixel A5; x=9..11 fetch nothing
        s_x = 10'd8; s_y = 10'd4; cycle();
        s_x = 10'd9; cycle();
        check_eq("fetch_addr_162", 32'(mem_addr), 32'd162);
        s_x = 10'd10; cycle();
        s_x = 10'd11; repeat (3) cycle();
        check_eq("pixel_A5", 32'(pixel_data), 32'hA5);

        // Write and fetch in the same IDLE cycle: fetch wins, write lands in N+4
        s_x = 10'd16; s_req = 1'b1; s_waddr = 15'd100; s_wdata = 8'h3C;
        cycle();
        repeat (4) cycle();
        check_eq("deferred_we",   32'(mem_we),     32'd1);
        check_eq("deferred_addr", 32'(mem_addr),   32'd100);
        check_eq("deferred_ack",  32'(wif.wr_ack), 32'd1);
        wait_writer_idle();

        // Out-of-range write, then valid writes with wr_err held
        s_von = 1'b0; s_x = 10'd1;
        cycle();
        s_req = 1'b1; s_waddr = 15'd19200; s_wdata = 8'hFF;
        cycle(); cycle();
        check_eq("oor_ack", 32'(wif.wr_ack), 32'd1);
        check_eq("oor_we",  32'(mem_we),     32'd0);
        wait_writer_idle();
        s_req = 1'b1; s_waddr = 15'd5; s_wdata = 8'h42;
        repeat (3) cycle();
        wait_writer_idle();
        check_eq("err_sticky", 32'(wif.wr_err), 32'd1);

        // Vblank-only writer blocked during active video, granted on video_on fall
        s_vbo = 1'b1; s_von = 1'b1; s_x = 10'd1; s_y = 10'd5;
        s_req = 1'b1; s_waddr = 15'd200; s_wdata = 8'h77;
        repeat (6) cycle();
        check_eq("vb_blocked_req_held", 32'(s_req), 32'd1);
        s_von = 1'b0;
        cycle(); cycle();
        check_eq("vb_ack", 32'(wif.wr_ack), 32'd1);
        check_eq("vb_pixel_clear", 32'(pixel_data), 32'd0);
        wait_writer_idle();

        // Back-to-back requests in vblank: one ack every 2nd cycle
        wr_mode = 2;
        new_request();
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (wif.wr_ack) acks++;
        end
        check_eq("b2b_ack_count", 32'(acks), 32'd6);
        wr_mode = 0;
        wait_writer_idle();

        // Randomized traffic with occasional resets
        sx = 0; sy = 0;
        for (int seg = 0; seg < 48; seg++) begin
            raster  = 1'($urandom_range(0, 1));
            s_vbo   = 1'($urandom_range(0, 1));
            wr_mode = $urandom_range(0, 2);
            for (int k = 0; k < 64; k++) begin
                if (raster) begin
                    sx = (sx + 1) % 48;
                    if (sx == 0) sy = (sy + 1) % 12;
                    s_x = 10'(sx); s_y = 10'(sy);
                    s_von = (sx < 40) && (sy < 10);
                end else begin
                    r = $urandom_range(0, 9);
                    if (r == 1) begin
                        s_x = '0; s_y = '0;
                    end else if (r == 2) begin
                        s_x = 10'd636; s_y = 10'd476;
                    end else if (r != 0) begin
                        s_x = 10'($urandom_range(0, 639));
                        s_y = 10'($urandom_range(0, 479));
                        if ($urandom_range(0, 1) == 1) s_x[1:0] = 2'b00;
                    end
                    s_von = ($urandom_range(0, 3) != 0);
                end
                s_rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                cycle();
            end
        end
        s_rst = 1'b1;
        wr_mode = 0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
